// File: rtl/setpoint_pkg.sv
// Shared definitions for the setpoint controller slice.
//   state_t          FSM state encoding (IDLE=0, DELAY=1, REPEAT=2, BOTH_LOCK=3)
//   DIR_UP/DIR_DOWN  auto-repeat direction encoding
//   DEF_*            default limits and restore value
package setpoint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DELAY     = 2'd1,
    ST_REPEAT    = 2'd2,
    ST_BOTH_LOCK = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_SUPERIOR_LIMIT = 500;
  localparam int DEF_INFERIOR_LIMIT = 0;
  localparam int DEF_DEFAULT_VALUE  = 204;

endpackage

// File: rtl/setpoint_controller_repeat_timer.sv
// Hold/auto-repeat timer for the setpoint controller.
// Counts cycles up to the hold delay or the repeat period and keeps a
// saturating count of expiries that selects the fast step size.
//   i_clk             system clock
//   i_reset           synchronous active-high reset
//   i_clear           zero both counters (wins over i_run)
//   i_run             advance the cycle counter
//   i_load_period_sel 0: compare against HOLD_DELAY, 1: against REPEAT_PERIOD
//   o_expire          high in the cycle the counter reaches its terminal value
//   o_fast            repeat count has reached FAST_AFTER
module repeat_timer #(
  parameter int HOLD_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int FAST_AFTER    = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_load_period_sel,
  output logic o_expire,
  output logic o_fast
);

  localparam int MAXL = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int RW   = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);

  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rep;
  logic [CW-1:0] w_last;
  logic          w_at_last;

  assign w_last    = i_load_period_sel ? CW'(REPEAT_PERIOD - 1) : CW'(HOLD_DELAY - 1);
  assign w_at_last = (r_cnt == w_last);
  assign o_expire  = i_run & ~i_clear & w_at_last;
  assign o_fast    = (r_rep >= RW'(FAST_AFTER));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
      r_rep <= '0;
    end else if (i_run) begin
      if (w_at_last) begin
        r_cnt <= '0;
        // Repeat count saturates so the fast step sticks for the rest of the hold.
        if (r_rep != RW'(FAST_AFTER)) r_rep <= r_rep + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/setpoint_controller.sv
// Setpoint register driven by debounced plus/minus buttons: saturating
// single steps, hold-to-auto-repeat with acceleration, both-button restore.
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_plus      debounced increment level
//   i_minus     debounced decrement level
//   o_register  current setpoint (registered)
//   o_changed   one-cycle pulse when o_register takes a new value
//   o_at_max    o_register == SUPERIOR_LIMIT
//   o_at_min    o_register == INFERIOR_LIMIT
//
// state     | meaning
// IDLE      | waiting for a fresh press or both buttons
// DELAY     | button held, waiting HOLD_DELAY before auto-repeat
// REPEAT    | auto-repeat, one step every REPEAT_PERIOD
// BOTH_LOCK | default restored, waiting for both buttons released
module setpoint_controller
  import setpoint_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int SUPERIOR_LIMIT = DEF_SUPERIOR_LIMIT,
  parameter int INFERIOR_LIMIT = DEF_INFERIOR_LIMIT,
  parameter int DEFAULT_VALUE  = DEF_DEFAULT_VALUE,
  parameter int HOLD_DELAY     = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000,
  parameter int FAST_AFTER     = 8,
  parameter int FAST_STEP      = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_plus,
  input  logic             i_minus,
  output logic [WIDTH-1:0] o_register,
  output logic             o_changed,
  output logic             o_at_max,
  output logic             o_at_min
);

  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(SUPERIOR_LIMIT);
  localparam logic [WIDTH-1:0] L_MIN  = WIDTH'(INFERIOR_LIMIT);
  localparam logic [WIDTH-1:0] L_DEF  = WIDTH'(DEFAULT_VALUE);
  localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] L_FAST = WIDTH'(FAST_STEP);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] st);
    logic [WIDTH:0] s;
    s = {1'b0, v} + {1'b0, st};
    return (s > {1'b0, L_MAX}) ? L_MAX : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] st);
    logic [WIDTH:0] floor_v;
    floor_v = {1'b0, L_MIN} + {1'b0, st};
    return ({1'b0, v} < floor_v) ? L_MIN : v - st;
  endfunction

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_register;
  logic             r_changed;
  logic             r_plus_q;
  logic             r_minus_q;

  logic             w_rise_p, w_rise_m, w_both, w_active;
  logic             w_run, w_clear, w_sel, w_expire, w_fast;
  logic [WIDTH-1:0] w_step_size, w_stepped, w_up1, w_dn1;

  always_comb begin
    w_rise_p    = i_plus & ~r_plus_q;
    w_rise_m    = i_minus & ~r_minus_q;
    w_both      = i_plus & i_minus;
    w_active    = (r_dir == DIR_UP) ? i_plus : i_minus;
    w_run       = (r_state == ST_DELAY) || (r_state == ST_REPEAT);
    w_sel       = (r_state == ST_REPEAT);
    // Timer is held at zero outside DELAY/REPEAT and on any exit from them.
    w_clear     = ~w_run | w_both | ~w_active;
    w_step_size = (w_sel && w_fast) ? L_FAST : L_ONE;
    w_stepped   = (r_dir == DIR_UP) ? sat_inc(r_register, w_step_size)
                                    : sat_dec(r_register, w_step_size);
    w_up1       = sat_inc(r_register, L_ONE);
    w_dn1       = sat_dec(r_register, L_ONE);
  end

  repeat_timer #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .FAST_AFTER   (FAST_AFTER)
  ) u_timer (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_clear          (w_clear),
    .i_run            (w_run),
    .i_load_period_sel(w_sel),
    .o_expire         (w_expire),
    .o_fast           (w_fast)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_UP;
      r_register <= L_DEF;
      r_changed  <= 1'b0;
      // Flops start high so a button held through reset is not seen as a press.
      r_plus_q   <= 1'b1;
      r_minus_q  <= 1'b1;
    end else begin
      r_plus_q  <= i_plus;
      r_minus_q <= i_minus;
      r_changed <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_both) begin
            r_register <= L_DEF;
            r_changed  <= (r_register != L_DEF);
            r_state    <= ST_BOTH_LOCK;
          end else if (w_rise_p && !i_minus) begin
            r_register <= w_up1;
            r_changed  <= (w_up1 != r_register);
            r_dir      <= DIR_UP;
            r_state    <= ST_DELAY;
          end else if (w_rise_m && !i_plus) begin
            r_register <= w_dn1;
            r_changed  <= (w_dn1 != r_register);
            r_dir      <= DIR_DOWN;
            r_state    <= ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (w_both) begin
            r_register <= L_DEF;
            r_changed  <= (r_register != L_DEF);
            r_state    <= ST_BOTH_LOCK;
          end else if (!w_active) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_register <= w_stepped;
            r_changed  <= (w_stepped != r_register);
            r_state    <= ST_REPEAT;
          end
        end
        ST_BOTH_LOCK: begin
          if (!i_plus && !i_minus) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_register = r_register;
  assign o_changed  = r_changed;
  assign o_at_max   = (r_register == L_MAX);
  assign o_at_min   = (r_register == L_MIN);

endmodule
